macc_dot_seq: RTL and testbench

Sequencer that drives the single-cycle MACC unit to compute one dot product per command: sum of a[i]*b[i] for i in 0..len-1, plus a bias. It sits between two operand streams (weights/activations) and the MACC datapath. It handles the MACC accumulator feedback internally, because MACC clears its output whenever its inputs are not valid. It returns the final sum on an output stream with backpressure.

---
 rtl/macc_dot_seq_if.sv | 84 ++++++++
 rtl/macc_dot_seq.sv | 144 ++++++++++++++
 tb/tb_macc_dot_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/macc_dot_seq_if.sv
// -----------------------------------------------------------------------------
// macc_dot_seq_if
//
// Signal bundle for the dot-product sequencer. It groups every handshake and
// bus signal around the sequencer:
//   - command:    cfg_start, cfg_len, cfg_bias, busy
//   - operand A:  s_axis_a_tdata / s_axis_a_tvalid / s_axis_a_tready
//   - operand B:  s_axis_b_tdata / s_axis_b_tvalid / s_axis_b_tready
//   - MACC drive: macc_{a,b,c}_tdata, macc_{a,b,c}_tvalid
//   - MACC reply: macc_result_tdata, macc_result_tvalid
//   - result:     m_axis_dot_tdata / m_axis_dot_tvalid / m_axis_dot_tready
//
// Modports:
//   slave  - the sequencer's view (receives commands and operands, drives the
//            MACC and the result stream)
//   master - the surrounding system's view (the exact mirror of slave)
// -----------------------------------------------------------------------------
interface macc_dot_seq_if #(
    parameter int BITWIDTH = 32,
    parameter int LENW     = 16
);

    // Command
    logic                cfg_start;
    logic [LENW-1:0]     cfg_len;
    logic [BITWIDTH-1:0] cfg_bias;
    logic                busy;

    // Operand A stream
    logic [BITWIDTH-1:0] s_axis_a_tdata;
    logic                s_axis_a_tvalid;
    logic                s_axis_a_tready;

    // Operand B stream
    logic [BITWIDTH-1:0] s_axis_b_tdata;
    logic                s_axis_b_tvalid;
    logic                s_axis_b_tready;

    // MACC operands
    logic [BITWIDTH-1:0] macc_a_tdata;
    logic [BITWIDTH-1:0] macc_b_tdata;
    logic [BITWIDTH-1:0] macc_c_tdata;
    logic                macc_a_tvalid;
    logic                macc_b_tvalid;
    logic                macc_c_tvalid;

    // MACC result
    logic [BITWIDTH-1:0] macc_result_tdata;
    logic                macc_result_tvalid;

    // Dot-product result stream
    logic [BITWIDTH-1:0] m_axis_dot_tdata;
    logic                m_axis_dot_tvalid;
    logic                m_axis_dot_tready;

    modport slave (
        input  cfg_start, cfg_len, cfg_bias,
        output busy,
        input  s_axis_a_tdata, s_axis_a_tvalid,
        output s_axis_a_tready,
        input  s_axis_b_tdata, s_axis_b_tvalid,
        output s_axis_b_tready,
        output macc_a_tdata, macc_b_tdata, macc_c_tdata,
        output macc_a_tvalid, macc_b_tvalid, macc_c_tvalid,
        input  macc_result_tdata, macc_result_tvalid,
        output m_axis_dot_tdata, m_axis_dot_tvalid,
        input  m_axis_dot_tready
    );

    modport master (
        output cfg_start, cfg_len, cfg_bias,
        input  busy,
        output s_axis_a_tdata, s_axis_a_tvalid,
        input  s_axis_a_tready,
        output s_axis_b_tdata, s_axis_b_tvalid,
        input  s_axis_b_tready,
        input  macc_a_tdata, macc_b_tdata, macc_c_tdata,
        input  macc_a_tvalid, macc_b_tvalid, macc_c_tvalid,
        output macc_result_tdata, macc_result_tvalid,
        input  m_axis_dot_tdata, m_axis_dot_tvalid,
        output m_axis_dot_tready
    );

endinterface : macc_dot_seq_if

// File: rtl/macc_dot_seq.sv
// -----------------------------------------------------------------------------
// macc_dot_seq
//
// Sequences a single-cycle MACC unit (result <= a*b + c, registered, cleared
// whenever its inputs are not valid) to compute one dot product per command:
//     dot = cfg_bias + sum_{i=0}^{len-1} a[i]*b[i]      (mod 2^BITWIDTH)
//
// Ports:
//   aclk     - clock
//   aresetn  - asynchronous active-low reset
//   bus      - macc_dot_seq_if.slave: command (cfg_*/busy), operand streams
//              s_axis_a / s_axis_b, MACC operand/result signals, and the
//              result stream m_axis_dot
//
// Behaviour:
//   IDLE  : waits for cfg_start; len == 0 goes straight to OUT with dot = bias.
//   RUN   : consumes A and B jointly, one element per fire, feeding the MACC.
//   DRAIN : one cycle to capture the final MACC result into dot.
//   OUT   : presents dot until the downstream handshake, then back to IDLE.
//
// The MACC zeroes its output when not fed, so the running sum is kept in acc.
// The c operand is forwarded straight from the MACC result when it is valid,
// which lets fires run back to back without waiting for acc to update.
// -----------------------------------------------------------------------------
module macc_dot_seq #(
    parameter int BITWIDTH = 32,
    parameter int LENW     = 16
) (
    input logic           aclk,
    input logic           aresetn,
    macc_dot_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t              state;
    logic [BITWIDTH-1:0] acc;   // running sum between MACC results
    logic [BITWIDTH-1:0] dot;   // final result held for the output stream
    logic [LENW-1:0]     len;   // element count of the current command
    logic [LENW-1:0]     cnt;   // elements consumed so far

    logic in_run;
    logic fire;
    logic last_elem;

    // -------------------------------------------------------------------------
    // Stream handshake and MACC drive
    // -------------------------------------------------------------------------
    assign in_run    = (state == RUN);
    assign fire      = in_run & bus.s_axis_a_tvalid & bus.s_axis_b_tvalid;

    // len is never zero in RUN, so len-1 cannot underflow here.
    assign last_elem = (cnt == len - LENW'(1));

    // Each stream is only accepted together with the other one, so neither
    // side can run ahead and an element is never consumed without its partner.
    assign bus.s_axis_a_tready = in_run & bus.s_axis_b_tvalid;
    assign bus.s_axis_b_tready = in_run & bus.s_axis_a_tvalid;

    assign bus.macc_a_tdata  = bus.s_axis_a_tdata;
    assign bus.macc_b_tdata  = bus.s_axis_b_tdata;
    // The result of the previous fire is not in acc yet, so forward it.
    assign bus.macc_c_tdata  = bus.macc_result_tvalid ? bus.macc_result_tdata : acc;

    assign bus.macc_a_tvalid = fire;
    assign bus.macc_b_tvalid = fire;
    assign bus.macc_c_tvalid = fire;

    // -------------------------------------------------------------------------
    // Status and result stream (straight from registers)
    // -------------------------------------------------------------------------
    assign bus.busy              = (state != IDLE);
    assign bus.m_axis_dot_tvalid = (state == OUT);
    assign bus.m_axis_dot_tdata  = dot;

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; blocking assignments would make acc/cnt/state depend
    // on statement order within the block.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            acc   <= '0;
            dot   <= '0;
            len   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cfg_start) begin
                        len <= bus.cfg_len;
                        acc <= bus.cfg_bias;
                        cnt <= '0;
                        if (bus.cfg_len == '0) begin
                            dot   <= bus.cfg_bias;
                            state <= OUT;
                        end else begin
                            state <= RUN;
                        end
                    end
                end

                RUN: begin
                    // A stall lets the last result land in acc; the MACC
                    // then clears, and the next fire picks acc up as c.
                    if (bus.macc_result_tvalid) begin
                        acc <= bus.macc_result_tdata;
                    end
                    if (fire) begin
                        cnt <= cnt + LENW'(1);
                        if (last_elem) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The MACC result from the final fire is valid this cycle.
                    if (bus.macc_result_tvalid) begin
                        acc <= bus.macc_result_tdata;
                    end
                    dot   <= bus.macc_result_tdata;
                    state <= OUT;
                end

                OUT: begin
                    if (bus.m_axis_dot_tready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : macc_dot_seq

// File: tb/tb_macc_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_macc_dot_seq
//
// Directed bench for macc_dot_seq with a behavioural single-cycle MACC
// attached. Inputs change 1 ns after the rising edge; outputs are sampled
// once the inputs of that cycle have settled.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_macc_dot_seq;

    localparam int BITWIDTH = 32;
    localparam int LENW     = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BITWIDTH-1:0] vec_a [8];
    logic [BITWIDTH-1:0] vec_b [8];

    macc_dot_seq_if #(.BITWIDTH(BITWIDTH), .LENW(LENW)) bus ();

    macc_dot_seq #(.BITWIDTH(BITWIDTH), .LENW(LENW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    // Single-cycle MACC: registered a*b+c, output cleared when not fed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.macc_result_tvalid <= 1'b0;
            bus.macc_result_tdata  <= '0;
        end else if (bus.macc_a_tvalid & bus.macc_b_tvalid & bus.macc_c_tvalid) begin
            bus.macc_result_tvalid <= 1'b1;
            bus.macc_result_tdata  <= bus.macc_a_tdata * bus.macc_b_tdata + bus.macc_c_tdata;
        end else begin
            bus.macc_result_tvalid <= 1'b0;
            bus.macc_result_tdata  <= '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drop_streams();
        bus.s_axis_a_tvalid = 1'b0;
        bus.s_axis_b_tvalid = 1'b0;
    endtask

    // Issue a command with len > 0 and stream vec_a/vec_b through it. A is
    // valid every cycle, B every b_period-th cycle. Returns after the DRAIN
    // cycle, with the result expected on the output stream.
    task automatic run_cmd(input string tag, input logic [31:0] bias,
                           input int len, input int b_period);
        int  idx   = 0;
        int  cyc   = 0;
        logic b_v;
        bus.cfg_start = 1'b1;
        bus.cfg_len   = LENW'(len);
        bus.cfg_bias  = bias;
        tick();
        bus.cfg_start = 1'b0;
        check({tag, "_busy_after_start"}, bus.busy, 1);
        while (idx < len && cyc < 100) begin
            b_v = ((cyc % b_period) == 0);
            bus.s_axis_a_tvalid = 1'b1;
            bus.s_axis_a_tdata  = vec_a[idx];
            bus.s_axis_b_tvalid = b_v;
            bus.s_axis_b_tdata  = vec_b[idx];
            #1;
            check({tag, "_a_tready"}, bus.s_axis_a_tready, b_v);
            check({tag, "_b_tready"}, bus.s_axis_b_tready, 1);
            check({tag, "_macc_valid"}, bus.macc_a_tvalid, b_v);
            if (idx == 0 && b_v) check({tag, "_first_c_is_bias"}, bus.macc_c_tdata, bias);
            tick();
            if (b_v) idx++;
            cyc++;
        end
        drop_streams();
        check({tag, "_elements"}, idx, len);
        if (b_period == 1) check({tag, "_consecutive_fires"}, cyc, len);
        #1;
        check({tag, "_drain_no_tvalid"}, bus.m_axis_dot_tvalid, 0);
        check({tag, "_drain_busy"}, bus.busy, 1);
        check({tag, "_drain_result_valid"}, bus.macc_result_tvalid, 1);
        tick();
    endtask

    // Result on the output stream, then a handshake back to IDLE.
    task automatic take_out(input string tag, input logic [31:0] exp);
        check({tag, "_tvalid"}, bus.m_axis_dot_tvalid, 1);
        check({tag, "_tdata"}, bus.m_axis_dot_tdata, exp);
        bus.m_axis_dot_tready = 1'b1;
        tick();
        bus.m_axis_dot_tready = 1'b0;
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_idle_tvalid"}, bus.m_axis_dot_tvalid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_a_tready"}, bus.s_axis_a_tready, 0);
        check({tag, "_b_tready"}, bus.s_axis_b_tready, 0);
        check({tag, "_macc_valids"},
              {bus.macc_a_tvalid, bus.macc_b_tvalid, bus.macc_c_tvalid}, 0);
        check({tag, "_dot_tvalid"}, bus.m_axis_dot_tvalid, 0);
        check({tag, "_dot_tdata"}, bus.m_axis_dot_tdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cfg_start         = 1'b0;
        bus.cfg_len           = '0;
        bus.cfg_bias          = '0;
        bus.s_axis_a_tdata    = '0;
        bus.s_axis_a_tvalid   = 1'b0;
        bus.s_axis_b_tdata    = '0;
        bus.s_axis_b_tvalid   = 1'b0;
        bus.m_axis_dot_tready = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        check_reset_outputs("reset");
        aresetn = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // ---- Basic dot product: 10 + 5+12+21+32 = 80 ----
        vec_a[0] = 1; vec_a[1] = 2; vec_a[2] = 3; vec_a[3] = 4;
        vec_b[0] = 5; vec_b[1] = 6; vec_b[2] = 7; vec_b[3] = 8;
        bus.s_axis_a_tvalid = 1'b1;
        bus.s_axis_b_tvalid = 1'b1;
        #1;
        check("idle_no_tready", bus.s_axis_a_tready, 0);
        check("idle_no_macc_valid", bus.macc_a_tvalid, 0);
        run_cmd("basic", 32'd10, 4, 1);
        take_out("basic_out", 32'd80);

        // ---- Stalls and skew: B valid every 3rd cycle, still 80 ----
        run_cmd("skew", 32'd10, 4, 3);
        take_out("skew_out", 32'd80);

        // ---- Zero length: result is the bias one cycle after start ----
        bus.s_axis_a_tvalid = 1'b1;
        bus.s_axis_b_tvalid = 1'b1;
        bus.cfg_start = 1'b1;
        bus.cfg_len   = '0;
        bus.cfg_bias  = 32'h1234;
        tick();
        bus.cfg_start = 1'b0;
        #1;
        check("zero_a_tready", bus.s_axis_a_tready, 0);
        check("zero_b_tready", bus.s_axis_b_tready, 0);
        check("zero_macc_valid", bus.macc_a_tvalid, 0);
        drop_streams();
        take_out("zero_out", 32'h1234);

        // ---- Wrap and backpressure: 3 + 0xFFFFFFFF*2 = 1 (mod 2^32) ----
        vec_a[0] = 32'hFFFF_FFFF;
        vec_b[0] = 32'd2;
        run_cmd("wrap", 32'd3, 1, 1);
        for (int i = 0; i < 5; i++) begin
            bus.cfg_start = (i % 2 == 0);
            bus.cfg_len   = '0;
            bus.cfg_bias  = 32'hDEAD;
            check("bp_tvalid", bus.m_axis_dot_tvalid, 1);
            check("bp_tdata_stable", bus.m_axis_dot_tdata, 32'h1);
            check("bp_busy", bus.busy, 1);
            tick();
        end
        // cfg_start coincident with the handshake edge must be ignored.
        bus.cfg_start         = 1'b1;
        bus.cfg_bias          = 32'h55;
        bus.m_axis_dot_tready = 1'b1;
        check("wrap_tdata", bus.m_axis_dot_tdata, 32'h1);
        tick();
        bus.m_axis_dot_tready = 1'b0;
        check("handshake_idle", bus.busy, 0);
        check("coincident_start_ignored", bus.m_axis_dot_tvalid, 0);
        // One edge later the same cfg_start is accepted.
        tick();
        bus.cfg_start = 1'b0;
        take_out("restart_out", 32'h55);

        // ---- Reset mid-run after 3 fires ----
        bus.s_axis_a_tdata  = 32'd1;
        bus.s_axis_b_tdata  = 32'd1;
        bus.cfg_start = 1'b1;
        bus.cfg_len   = LENW'(8);
        bus.cfg_bias  = 32'd7;
        tick();
        bus.cfg_start = 1'b0;
        bus.s_axis_a_tvalid = 1'b1;
        bus.s_axis_b_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("midrun_busy", bus.busy, 1);
        check("midrun_macc_valid", bus.macc_a_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        tick();
        aresetn = 1'b1;
        drop_streams();
        tick();
        check_reset_outputs("after_midrun_reset");

        // ---- New command after reset: 0 + 15 + 24 = 39 ----
        vec_a[0] = 3; vec_a[1] = 4;
        vec_b[0] = 5; vec_b[1] = 6;
        run_cmd("post_reset_cmd", 32'd0, 2, 1);
        take_out("post_reset_out", 32'd39);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_macc_dot_seq
